// File: rtl/uart_pkg.sv
// Shared UART definitions: parity selection constants and FSM state encoding,
// common to the TX and RX sides.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO: rd_data always presents the current head entry.
// A write is refused while full, even if a read happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_ok, rd_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ok    = wr_en && !full;
        rd_ok    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so increments wrap modulo DEPTH.
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed frame serialiser with optional parity,
// 1-2 stop bits and gap-free back-to-back frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES     = 10416,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx
);

    localparam int unsigned CW = $clog2(CYCLES);
    localparam int unsigned IW = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 pop, load, cnt_last;
    logic                 fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (in_valid),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = busy_q;
    assign tx       = tx_q;
    assign cnt_last = (cnt_q == CW'(CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        load       = 1'b0;
        pop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                load  = !fifo_empty;
            end
            ST_START: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_last) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_last) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IW'(DATA_BITS - 1)) begin
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                    end
                end
            end
            ST_PARITY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_last) begin
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_last) begin
                    cnt_d = '0;
                    if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                        load    = !fifo_empty;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Shared pop path for IDLE and the final stop clock, so chained frames start with no gap.
        if (load) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = (PARITY == PAR_ODD) ? ~^head : ^head;
            cnt_d   = '0;
            state_d = ST_START;
        end

        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase

        busy_d = (state_d != ST_IDLE) || !fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule
